// File: rtl/ber_pkg.sv
// ber_pkg: shared constants, state type and helpers for the BER meter.
//   SYM_ZERO / SYM_ONE : reference symbol mapping for PRBS bit 0 / 1
//   ber_state_e        : meter state (idle, waiting for frame start, measuring)
//   popcount2          : number of set bits in a 2-bit vector
package ber_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_ONE  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StRun
  } ber_state_e;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/prbs_gen.sv
// prbs_gen: Fibonacci LFSR reference generator, shared by RX checker and TX side.
//   clk_fs  : symbol-domain clock
//   rst_n   : asynchronous active-low reset, loads PRBS_SEED
//   load    : synchronous reseed (priority over adv)
//   adv     : shift one step
//   bit_out : current PRBS bit (s[0])
module prbs_gen #(
  parameter int unsigned PRBS_LEN  = 10,
  parameter int unsigned PRBS_TAP  = 7,
  parameter int unsigned PRBS_SEED = 1
) (
  input  logic clk_fs,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic bit_out
);

  localparam logic [PRBS_LEN-1:0] Seed = PRBS_LEN'(PRBS_SEED);

  logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = Seed;
    end else if (adv) begin
      lfsr_d = {lfsr_q[PRBS_TAP] ^ lfsr_q[0], lfsr_q[PRBS_LEN-1:1]};
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[0];

endmodule

// File: rtl/ber_meter.sv
// ber_meter: symbol/bit error-rate meter for the QPSK receiver.
// Tracks frame position after frame sync, regenerates the reference PRBS per
// frame and accumulates payload errors over WIN_FRAMES frames.
//   clk_fs, rst_n      : symbol clock, async active-low reset
//   sym_en             : symbol strobe; state advances only on it (except lock loss)
//   lock               : frame sync locked; low forces idle and clears the window
//   frame_start        : restarts the frame (qualified with sym_en)
//   rx_sym             : received {I,Q}
//   ref_sym            : current reference symbol
//   frame_pos          : position of the symbol presented on the next sym_en
//   err_cnt, frame_cnt : running error / completed-frame counts of the window
//   err_disp           : result of the last completed window
//   disp_valid         : one-cycle pulse when err_disp updates
//   err_sat            : err_cnt clamped in the current window
module ber_meter
  import ber_pkg::*;
#(
  parameter int unsigned PRBS_LEN   = 10,
  parameter int unsigned PRBS_TAP   = 7,
  parameter int unsigned PRBS_SEED  = 1,
  parameter int unsigned FRAME_LEN  = 1027,
  parameter int unsigned PAY_START  = 2,
  parameter int unsigned PAY_END    = 1024,
  parameter int unsigned WIN_FRAMES = 1000,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned POS_W      = 11,
  parameter int unsigned BIT_MODE   = 0
) (
  input  logic             clk_fs,
  input  logic             rst_n,
  input  logic             sym_en,
  input  logic             lock,
  input  logic             frame_start,
  input  logic [1:0]       rx_sym,
  output logic [1:0]       ref_sym,
  output logic [POS_W-1:0] frame_pos,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] err_disp,
  output logic             disp_valid,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_sat
);

  localparam logic [POS_W-1:0] PosFirst  = POS_W'(PAY_START);
  localparam logic [POS_W-1:0] PosLast   = POS_W'(PAY_END);
  localparam logic [POS_W-1:0] PosWrap   = POS_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FcntLast  = CNT_W'(WIN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  ber_state_e       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             dv_q, dv_d;
  logic             sat_q, sat_d;

  logic             prbs_bit;
  logic             prbs_load;
  logic             prbs_adv;
  logic             in_payload;
  logic [1:0]       diff;
  logic [1:0]       inc;
  logic [CNT_W:0]   err_sum;

  prbs_gen #(
    .PRBS_LEN (PRBS_LEN),
    .PRBS_TAP (PRBS_TAP),
    .PRBS_SEED(PRBS_SEED)
  ) u_prbs (
    .clk_fs (clk_fs),
    .rst_n  (rst_n),
    .load   (prbs_load),
    .adv    (prbs_adv),
    .bit_out(prbs_bit)
  );

  assign ref_sym    = prbs_bit ? SYM_ONE : SYM_ZERO;
  assign in_payload = (state_q == StRun) && (pos_q >= PosFirst) && (pos_q <= PosLast);
  // Shift only after a real compare; reseed (load) wins over the shift.
  assign prbs_adv   = lock && sym_en && in_payload;

  always_comb begin
    diff    = rx_sym ^ ref_sym;
    inc     = (BIT_MODE != 0) ? popcount2(diff) : {1'b0, |diff};
    // Carry out of the widened sum means the count would pass CntMax.
    err_sum = {1'b0, err_q} + {{(CNT_W - 1){1'b0}}, inc};
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    err_d     = err_q;
    disp_d    = disp_q;
    fcnt_d    = fcnt_q;
    sat_d     = sat_q;
    dv_d      = 1'b0;
    prbs_load = 1'b0;

    if (!lock) begin
      // Lock loss discards the partial window but keeps the last result.
      state_d   = StIdle;
      pos_d     = '0;
      err_d     = '0;
      fcnt_d    = '0;
      sat_d     = 1'b0;
      prbs_load = 1'b1;
    end else if (sym_en) begin
      unique case (state_q)
        StIdle: state_d = StAlign;
        StAlign: begin
          if (frame_start) begin
            state_d   = StRun;
            pos_d     = '0;
            prbs_load = 1'b1;
          end
        end
        StRun: begin
          if (in_payload) begin
            err_d = err_sum[CNT_W] ? CntMax : err_sum[CNT_W-1:0];
            sat_d = sat_q | err_sum[CNT_W];
          end
          if (frame_start) begin
            pos_d     = '0;
            prbs_load = 1'b1;
          end else if (pos_q == PosWrap) begin
            pos_d     = '0;
            prbs_load = 1'b1;
            if (fcnt_q == FcntLast) begin
              disp_d = err_d;
              dv_d   = 1'b1;
              err_d  = '0;
              fcnt_d = '0;
              sat_d  = 1'b0;
            end else begin
              fcnt_d = fcnt_q + CNT_W'(1);
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pos_q   <= '0;
      err_q   <= '0;
      disp_q  <= '0;
      fcnt_q  <= '0;
      dv_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
      fcnt_q  <= fcnt_d;
      dv_q    <= dv_d;
      sat_q   <= sat_d;
    end
  end

  assign frame_pos  = pos_q;
  assign err_cnt    = err_q;
  assign err_disp   = disp_q;
  assign frame_cnt  = fcnt_q;
  assign disp_valid = dv_q;
  assign err_sat    = sat_q;

endmodule

// File: tb/tb_ber_meter.sv
// tb_ber_meter: directed bench for ber_meter with a spec-level reference model.
// Three instances share frame control: A (defaults, symbol mode), B (bit mode),
// C (4-bit counter, fed an always-wrong symbol so it saturates every window).
// The window is shortened to 4 frames to keep run time small.
module tb_ber_meter;

  localparam int FL  = 1027;
  localparam int PS  = 2;
  localparam int PE  = 1024;
  localparam int WIN = 4;
  localparam int PER = 1023;

  logic clk_fs = 1'b0;
  logic rst_n  = 1'b0;
  logic sym_en = 1'b0;
  logic lock   = 1'b0;
  logic frame_start = 1'b0;
  logic [1:0] rx_a = 2'b00;
  logic [1:0] rx_c = 2'b00;

  logic [1:0]  ref_a, ref_b, ref_c;
  logic [10:0] pos_a, pos_b, pos_c;
  logic [19:0] err_a, err_b, disp_a, disp_b, fcnt_a, fcnt_b;
  logic [3:0]  err_c, disp_c, fcnt_c;
  logic        dv_a, dv_b, dv_c, sat_a, sat_b, sat_c;

  always #5 clk_fs = ~clk_fs;

  ber_meter #(.WIN_FRAMES(WIN)) dut_a (
    .clk_fs(clk_fs), .rst_n(rst_n), .sym_en(sym_en), .lock(lock),
    .frame_start(frame_start), .rx_sym(rx_a), .ref_sym(ref_a), .frame_pos(pos_a),
    .err_cnt(err_a), .err_disp(disp_a), .disp_valid(dv_a), .frame_cnt(fcnt_a),
    .err_sat(sat_a)
  );

  ber_meter #(.WIN_FRAMES(WIN), .BIT_MODE(1)) dut_b (
    .clk_fs(clk_fs), .rst_n(rst_n), .sym_en(sym_en), .lock(lock),
    .frame_start(frame_start), .rx_sym(rx_a), .ref_sym(ref_b), .frame_pos(pos_b),
    .err_cnt(err_b), .err_disp(disp_b), .disp_valid(dv_b), .frame_cnt(fcnt_b),
    .err_sat(sat_b)
  );

  ber_meter #(.WIN_FRAMES(WIN), .CNT_W(4)) dut_c (
    .clk_fs(clk_fs), .rst_n(rst_n), .sym_en(sym_en), .lock(lock),
    .frame_start(frame_start), .rx_sym(rx_c), .ref_sym(ref_c), .frame_pos(pos_c),
    .err_cnt(err_c), .err_disp(disp_c), .disp_valid(dv_c), .frame_cnt(fcnt_c),
    .err_sat(sat_c)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  bit mon_en   = 1'b0;
  bit lit_en   = 1'b0;
  int gap_i    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit prbs_seq [PER + 10];
  int m_state;  // 0 idle, 1 waiting for frame start, 2 measuring
  int m_pos, m_fcnt;
  bit m_dv;
  int m_err [3];
  int m_disp[3];
  bit m_sat [3];
  int max_c [3] = '{1048575, 1048575, 15};
  int mode_c[3] = '{0, 1, 0};

  // Reference follows the sequence index: reseeded at frame start, advanced
  // once per payload symbol.
  function automatic logic [1:0] model_ref();
    int idx;
    if (m_state != 2 || m_pos < PS) idx = 0;
    else if (m_pos > PE) idx = (PE - PS + 1) % PER;
    else idx = (m_pos - PS) % PER;
    return prbs_seq[idx] ? 2'b11 : 2'b01;
  endfunction

  logic [1:0] ms_ref, ms_d;
  int ms_inc, ms_sum;

  always @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pos = 0; m_fcnt = 0; m_dv = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_err[k] = 0; m_disp[k] = 0; m_sat[k] = 1'b0;
      end
    end else begin
      ms_ref = model_ref();
      m_dv = 1'b0;
      if (!lock) begin
        m_state = 0; m_pos = 0; m_fcnt = 0;
        for (int k = 0; k < 3; k++) begin
          m_err[k] = 0; m_sat[k] = 1'b0;
        end
      end else if (sym_en) begin
        if (m_state == 0) begin
          m_state = 1;
        end else if (m_state == 1) begin
          if (frame_start) begin
            m_state = 2; m_pos = 0;
          end
        end else begin
          if (m_pos >= PS && m_pos <= PE) begin
            for (int k = 0; k < 3; k++) begin
              ms_d = ((k == 2) ? rx_c : rx_a) ^ ms_ref;
              ms_inc = (mode_c[k] != 0) ? (int'(ms_d[0]) + int'(ms_d[1])) : int'(ms_d != 2'b00);
              ms_sum = m_err[k] + ms_inc;
              if (ms_sum > max_c[k]) begin
                ms_sum = max_c[k];
                m_sat[k] = 1'b1;
              end
              m_err[k] = ms_sum;
            end
          end
          if (frame_start) begin
            m_pos = 0;
          end else if (m_pos == FL - 1) begin
            m_pos = 0;
            m_fcnt++;
            if (m_fcnt == WIN) begin
              m_fcnt = 0;
              m_dv = 1'b1;
              for (int k = 0; k < 3; k++) begin
                m_disp[k] = m_err[k]; m_err[k] = 0; m_sat[k] = 1'b0;
              end
            end
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] o_ref[3], o_pos[3], o_err[3], o_disp[3], o_fcnt[3], o_dv[3], o_sat[3];
  always_comb begin
    o_ref[0] = 32'(ref_a);  o_ref[1] = 32'(ref_b);  o_ref[2] = 32'(ref_c);
    o_pos[0] = 32'(pos_a);  o_pos[1] = 32'(pos_b);  o_pos[2] = 32'(pos_c);
    o_err[0] = 32'(err_a);  o_err[1] = 32'(err_b);  o_err[2] = 32'(err_c);
    o_disp[0] = 32'(disp_a); o_disp[1] = 32'(disp_b); o_disp[2] = 32'(disp_c);
    o_fcnt[0] = 32'(fcnt_a); o_fcnt[1] = 32'(fcnt_b); o_fcnt[2] = 32'(fcnt_c);
    o_dv[0] = 32'(dv_a);    o_dv[1] = 32'(dv_b);    o_dv[2] = 32'(dv_c);
    o_sat[0] = 32'(sat_a);  o_sat[1] = 32'(sat_b);  o_sat[2] = 32'(sat_c);
  end

  always @(negedge clk_fs) begin
    if (rst_n && mon_en) begin
      if (dv_a === 1'b1) dv_count++;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ref_sym[%0d]", k), o_ref[k], 32'(model_ref()));
        chk($sformatf("frame_pos[%0d]", k), o_pos[k], 32'(m_pos));
        chk($sformatf("err_cnt[%0d]", k), o_err[k], 32'(m_err[k]));
        chk($sformatf("err_disp[%0d]", k), o_disp[k], 32'(m_disp[k]));
        chk($sformatf("frame_cnt[%0d]", k), o_fcnt[k], 32'(m_fcnt));
        chk($sformatf("disp_valid[%0d]", k), o_dv[k], 32'(m_dv));
        chk($sformatf("err_sat[%0d]", k), o_sat[k], 32'(m_sat[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] lit_ref [11];

  task automatic step(input logic se, input logic lk, input logic fs);
    @(negedge clk_fs);
    sym_en = se; lock = lk; frame_start = fs; rx_a = 2'b00; rx_c = 2'b00;
  endtask

  // One symbol, with an idle gap before every fifth one.
  // mode 0: ideal; 1: error at pos 3 (ref 01); 2: errors at pos 0, 1, 1025.
  task automatic sym(input int mode);
    int p;
    logic [1:0] r;
    if (gap_i % 5 == 4) step(1'b0, 1'b1, 1'b0);
    gap_i++;
    @(negedge clk_fs);
    p = m_pos;
    r = model_ref();
    if (lit_en && m_state == 2 && p >= 2 && p <= 12)
      chk($sformatf("lit_ref_pos%0d", p), 32'(ref_a), 32'(lit_ref[p-2]));
    if ((mode == 1 && p == 3) || (mode == 2 && (p == 0 || p == 1 || p == 1025)))
      rx_a = 2'b10;
    else
      rx_a = r;
    rx_c = 2'b00;
    sym_en = 1'b1; lock = 1'b1; frame_start = 1'b0;
  endtask

  task automatic window(input int mode, input int exp_a, input int exp_b);
    int dv0;
    dv0 = dv_count;
    repeat (WIN * FL - 1) sym(mode);
    step(1'b0, 1'b1, 1'b0);
    #1;
    chk("pre_err_a", 32'(err_a), 32'(exp_a));
    chk("pre_err_b", 32'(err_b), 32'(exp_b));
    chk("pre_fcnt", 32'(fcnt_a), 32'(WIN - 1));
    chk("pre_pos", 32'(pos_a), 32'(FL - 1));
    chk("pre_err_c_clamped", 32'(err_c), 32'd15);
    chk("pre_sat_c", 32'(sat_c), 32'd1);
    chk("pre_no_dv", 32'(dv_count), 32'(dv0));
    sym(mode);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #1;
    chk("dv_once", 32'(dv_count), 32'(dv0 + 1));
    chk("disp_a", 32'(disp_a), 32'(exp_a));
    chk("disp_b", 32'(disp_b), 32'(exp_b));
    chk("disp_c", 32'(disp_c), 32'd15);
    chk("post_sat_c", 32'(sat_c), 32'd0);
    chk("post_err_a", 32'(err_a), 32'd0);
    chk("post_fcnt", 32'(fcnt_a), 32'd0);
  endtask

  initial begin
    // Sequence from the recurrence a[n+10] = a[n+7] ^ a[n], seeded with 1.
    for (int i = 0; i < 10; i++) prbs_seq[i] = (i == 0);
    for (int i = 0; i < PER; i++) prbs_seq[i+10] = prbs_seq[i+7] ^ prbs_seq[i];

    // Hand-derived: seed 1 gives bit 1, nine zeros, then 1 (positions 2..12).
    lit_ref[0] = 2'b11;
    for (int i = 1; i < 10; i++) lit_ref[i] = 2'b01;
    lit_ref[10] = 2'b11;

    repeat (3) @(negedge clk_fs);
    #1;
    chk("rst_ref", 32'(ref_a), 32'd3);
    chk("rst_pos", 32'(pos_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_disp", 32'(disp_a), 32'd0);
    chk("rst_dv", 32'(dv_a), 32'd0);
    chk("rst_fcnt", 32'(fcnt_a), 32'd0);
    chk("rst_sat", 32'(sat_c), 32'd0);

    @(negedge clk_fs);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);  // idle -> align
    step(1'b1, 1'b1, 1'b0);  // stays in align
    step(1'b1, 1'b1, 1'b1);  // frame start -> run

    lit_en = 1'b1;
    window(0, 0, 0);
    lit_en = 1'b0;
    window(2, 0, 0);
    window(1, WIN, 2 * WIN);

    // Partial window with errors, then a one-cycle lock drop.
    repeat (2 * FL + 500) sym(1);
    step(1'b0, 1'b1, 1'b0);
    #1;
    chk("partial_err_a", 32'(err_a), 32'd3);
    chk("partial_fcnt", 32'(fcnt_a), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #1;
    chk("unlock_err_a", 32'(err_a), 32'd0);
    chk("unlock_err_b", 32'(err_b), 32'd0);
    chk("unlock_fcnt", 32'(fcnt_a), 32'd0);
    chk("unlock_sat_c", 32'(sat_c), 32'd0);
    chk("unlock_disp_a", 32'(disp_a), 32'(WIN));
    chk("unlock_disp_b", 32'(disp_b), 32'(2 * WIN));

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    window(0, 0, 0);

    step(1'b0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
